// File: rtl/uart_mmio.sv
// uart_mmio: MEM-stage bridge mapping loads/stores at 0xBF00 (data) and 0xBF01 (status) onto the UART chip.
// Optional feature macro UART_RX_FIFO_EN adds a 4-entry receive FIFO filled by background reads.
module uart_mmio (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] Addr,
  input  logic [15:0] WrData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [15:0] RdData,
  output logic        Stall,
  output logic        UartSel,
  inout  wire  [15:0] Ram1_data,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);

  // state      | meaning
  // IDLE       | sample strobes/Addr; serve status reads and FIFO pops
  // RD_STROBE  | rdn low for two cycles; byte latched on the second
  // RD_CAPTURE | rdn high; latched byte returned (CPU) or pushed (background)
  // WR_SETUP   | bus driven with the store byte, wrn high
  // WR_STROBE  | wrn low for two cycles, bus held
  // WR_DRAIN   | bus released; wait for tbre & tsre
  typedef enum logic [2:0] {
    IDLE, RD_STROBE, RD_CAPTURE, WR_SETUP, WR_STROBE, WR_DRAIN
  } state_t;

  state_t     state_q, state_d;
  logic       cnt_q, cnt_d;
  logic       fg_q, fg_d;
  logic       done_q, done_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       drive;
  logic       req, req_wr, req_data_rd, req_stat_rd, rx_ready;
  logic       fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [7:0] fifo_head;
  logic       unused_bits;

  assign req         = (Addr[15:1] == 15'h5F80) & (MemRead | MemWrite);
  assign UartSel     = req;
  assign req_wr      = req & MemWrite & ~Addr[0];
  assign req_data_rd = req & ~MemWrite & ~Addr[0];
  assign req_stat_rd = req & ~MemWrite & Addr[0];
  assign rx_ready    = data_ready | ~fifo_empty;
  assign Ram1_data   = drive ? {8'h00, tx_byte_q} : 16'hzzzz;

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_mem_q [4];
  logic [7:0] fifo_mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;

  assign fifo_empty  = (count_q == 3'd0);
  assign fifo_full   = count_q[2];
  assign fifo_head   = fifo_mem_q[rd_ptr_q];
  assign unused_bits = ^{WrData[15:8], Ram1_data[15:8]};

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (fifo_push) begin
      fifo_mem_d[wr_ptr_q] = rx_byte_q;
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    if (fifo_pop) rd_ptr_d = rd_ptr_q + 2'd1;
    count_d = count_q + {2'b00, fifo_push} - {2'b00, fifo_pop};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clk) fifo_mem_q <= fifo_mem_d;
`else
  assign fifo_empty  = 1'b1;
  assign fifo_full   = 1'b1;
  assign fifo_head   = 8'h00;
  assign unused_bits = ^{WrData[15:8], Ram1_data[15:8], fifo_push, fifo_pop};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fg_d      = fg_q;
    done_d    = 1'b0;
    rx_byte_d = rx_byte_q;
    tx_byte_d = tx_byte_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    Stall     = 1'b0;
    RdData    = 16'h0000;
    rdn       = 1'b1;
    wrn       = 1'b1;
    drive     = 1'b0;
    case (state_q)
      // done_q marks the cycle a finished write is still presented while the pipeline advances
      IDLE: if (!done_q) begin
        if (req_wr) begin
          state_d   = WR_SETUP;
          tx_byte_d = WrData[7:0];
          Stall     = 1'b1;
        end else if (req_stat_rd) begin
          RdData = {14'b0, rx_ready, tbre & tsre};
        end else if (req_data_rd) begin
          if (!fifo_empty) begin
            RdData   = {8'h00, fifo_head};
            fifo_pop = 1'b1;
          end else if (data_ready) begin
            state_d = RD_STROBE;
            cnt_d   = 1'b1;
            fg_d    = 1'b1;
            Stall   = 1'b1;
          end
        end else if (!req && data_ready && !fifo_full) begin
          state_d = RD_STROBE;
          cnt_d   = 1'b1;
          fg_d    = 1'b0;
        end
      end
      RD_STROBE: begin
        rdn   = 1'b0;
        Stall = fg_q | req;
        if (cnt_q == 1'b0) begin
          state_d   = RD_CAPTURE;
          rx_byte_d = Ram1_data[7:0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_CAPTURE: begin
        state_d = IDLE;
        if (fg_q) begin
          RdData = {8'h00, rx_byte_q};
        end else begin
          fifo_push = 1'b1;
          Stall     = req;
        end
      end
      WR_SETUP: begin
        Stall   = 1'b1;
        drive   = 1'b1;
        state_d = WR_STROBE;
        cnt_d   = 1'b1;
      end
      WR_STROBE: begin
        Stall = 1'b1;
        drive = 1'b1;
        wrn   = 1'b0;
        if (cnt_q == 1'b0) state_d = WR_DRAIN;
        else               cnt_d   = cnt_q - 1'b1;
      end
      WR_DRAIN: begin
        Stall = 1'b1;
        if (tbre && tsre) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (Rst) begin
      Stall  = 1'b0;
      RdData = 16'h0000;
      rdn    = 1'b1;
      wrn    = 1'b1;
      drive  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      cnt_q     <= 1'b0;
      fg_q      <= 1'b0;
      done_q    <= 1'b0;
      rx_byte_q <= 8'h00;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fg_q      <= fg_d;
      done_q    <= done_d;
      rx_byte_q <= rx_byte_d;
      tx_byte_q <= tx_byte_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: randomized MMIO traffic against a queue-based UART chip model.
// The background-FIFO scenario replaces the direct-read scenarios when UART_RX_FIFO_EN is defined.
`timescale 1ns/1ps
module tb_uart_mmio;
  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] Addr, WrData;
  logic        MemRead, MemWrite;
  logic [15:0] RdData;
  logic        Stall, UartSel, rdn, wrn;
  logic        data_ready, tbre, tsre;
  wire  [15:0] Ram1_data;
  logic [7:0]  chip_byte;
  logic        rdn_prev;
  logic [7:0]  rxq[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 Clk = ~Clk;

  // UART chip: drives its pending byte while rdn is low; upper byte is junk the block must mask
  assign Ram1_data = (rdn == 1'b0) ? {8'hC3, chip_byte} : 16'hzzzz;

  uart_mmio dut (
    .Clk(Clk), .Rst(Rst), .Addr(Addr), .WrData(WrData), .MemRead(MemRead), .MemWrite(MemWrite),
    .RdData(RdData), .Stall(Stall), .UartSel(UartSel), .Ram1_data(Ram1_data), .rdn(rdn), .wrn(wrn),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  // one byte leaves the chip each time rdn returns high
  initial begin
    data_ready = 1'b0;
    chip_byte  = 8'h00;
    rdn_prev   = 1'b1;
    forever begin
      @(posedge Clk);
      #2;
      if (rdn_prev == 1'b0 && rdn == 1'b1 && rxq.size() != 0) rxq.delete(0);
      rdn_prev   = rdn;
      data_ready = (rxq.size() != 0);
      chip_byte  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_idle();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Addr     = 16'h0000;
    WrData   = 16'h0000;
  endtask

  task automatic test_reset();
    Rst = 1'b1; bus_idle(); tbre = 1'b1; tsre = 1'b1;
    step();
    Addr = 16'hBF00; MemWrite = 1'b1; WrData = 16'h00AA;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", Stall); end
      n_vec++; if (wrn !== 1'b1) begin n_err++; $display("FAIL reset_wrn: got %b want 1", wrn); end
      n_vec++; if (rdn !== 1'b1) begin n_err++; $display("FAIL reset_rdn: got %b want 1", rdn); end
      n_vec++; if (RdData !== 16'h0000) begin n_err++; $display("FAIL reset_rddata: got %h want 0000", RdData); end
      step();
    end
    bus_idle(); Rst = 1'b0;
    @(negedge Clk);
    n_vec++; if (UartSel !== 1'b0) begin n_err++; $display("FAIL reset_uartsel: got %b want 0", UartSel); end
    n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_idle_stall: got %b want 0", Stall); end
  endtask

  task automatic test_status();
    for (int i = 0; i < 8; i++) begin
      logic be, se, dr;
      logic [15:0] exp;
      be = (i == 0) ? 1'b1 : 1'($urandom);
      se = (i == 0) ? 1'b1 : 1'($urandom);
      dr = (i == 0) ? 1'b1 : 1'($urandom);
      step();
      tbre = be; tsre = se;
      if (dr) rxq.push_back(8'($urandom));
      Addr = 16'hBF01; MemRead = 1'b1; MemWrite = 1'b0;
      exp = {14'b0, dr, be & se};
      @(negedge Clk);
      n_vec++; if (RdData !== exp) begin n_err++; $display("FAIL status_rddata[%0d]: got %h want %h", i, RdData, exp); end
      n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL status_stall[%0d]: got %b want 0", i, Stall); end
      n_vec++; if (UartSel !== 1'b1) begin n_err++; $display("FAIL status_uartsel[%0d]: got %b want 1", i, UartSel); end
      step();
      bus_idle(); rxq.delete();
    end
    tbre = 1'b1; tsre = 1'b1;
  endtask

  task automatic test_read();
    for (int i = 0; i < 5; i++) begin
      logic [7:0]  b;
      logic [15:0] got;
      int stall_n, rdn_low, both_low;
      logic done;
      b = (i == 0) ? 8'h5A : 8'($urandom);
      step();
      rxq.push_back(b);
      Addr = 16'hBF00; MemRead = 1'b1; MemWrite = 1'b0;
      stall_n = 0; rdn_low = 0; both_low = 0; done = 1'b0; got = 16'hxxxx;
      for (int c = 0; c < 12 && !done; c++) begin
        if (c != 0) step();
        @(negedge Clk);
        if (!rdn) rdn_low++;
        if (!rdn && !wrn) both_low++;
        if (Stall) stall_n++;
        else begin done = 1'b1; got = RdData; end
      end
      step();
      bus_idle();
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL read_timeout[%0d]: stall still %b after 12 cycles", i, Stall); end
      n_vec++; if (got !== {8'h00, b}) begin n_err++; $display("FAIL read_data[%0d]: got %h want %h", i, got, {8'h00, b}); end
      n_vec++; if (stall_n != 3) begin n_err++; $display("FAIL read_stall_cycles[%0d]: got %0d want 3", i, stall_n); end
      n_vec++; if (rdn_low != 2) begin n_err++; $display("FAIL read_rdn_cycles[%0d]: got %0d want 2", i, rdn_low); end
      n_vec++; if (both_low != 0) begin n_err++; $display("FAIL read_strobe_overlap[%0d]: got %0d want 0", i, both_low); end
      n_vec++; if (rxq.size() != 0) begin n_err++; $display("FAIL read_consumed[%0d]: chip holds %0d want 0", i, rxq.size()); end
      @(negedge Clk);
      n_vec++; if (rdn !== 1'b1) begin n_err++; $display("FAIL read_no_extra_pulse[%0d]: got rdn %b want 1", i, rdn); end
    end
  endtask

  task automatic test_read_empty();
    step();
    Addr = 16'hBF00; MemRead = 1'b1; MemWrite = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      n_vec++; if (RdData !== 16'h0000) begin n_err++; $display("FAIL empty_rddata[%0d]: got %h want 0000", c, RdData); end
      n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL empty_stall[%0d]: got %b want 0", c, Stall); end
      n_vec++; if (rdn !== 1'b1) begin n_err++; $display("FAIL empty_rdn[%0d]: got %b want 1", c, rdn); end
      step();
    end
    bus_idle();
  endtask

  task automatic test_write();
    for (int i = 0; i < 5; i++) begin
      logic [15:0] wd;
      int d, stall_n, wrn_low, rdn_low, bus_bad;
      logic done;
      wd = (i == 0) ? 16'h1241 : 16'($urandom);
      d  = (i == 0) ? 5 : int'($urandom_range(0, 4));
      step();
      Addr = 16'hBF00; MemWrite = 1'b1; MemRead = (i == 1) ? 1'b1 : 1'($urandom);
      WrData = wd; tbre = 1'b1; tsre = 1'b0;
      stall_n = 0; wrn_low = 0; rdn_low = 0; bus_bad = 0; done = 1'b0;
      for (int c = 0; c < 24 && !done; c++) begin
        if (c != 0) begin
          step();
          WrData = 16'($urandom);
          tsre = (c >= 4 + d);
        end
        @(negedge Clk);
        if (!wrn) begin
          wrn_low++;
          if (Ram1_data !== {8'h00, wd[7:0]}) begin
            bus_bad++;
            $display("FAIL write_bus[%0d]: got %h want %h", i, Ram1_data, {8'h00, wd[7:0]});
          end
        end
        if (!rdn) rdn_low++;
        if (Stall) stall_n++;
        else done = 1'b1;
      end
      step();
      bus_idle(); tsre = 1'b1;
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL write_timeout[%0d]: stall still %b", i, Stall); end
      n_vec++; if (stall_n != 5 + d) begin n_err++; $display("FAIL write_stall_cycles[%0d]: got %0d want %0d", i, stall_n, 5 + d); end
      n_vec++; if (wrn_low != 2) begin n_err++; $display("FAIL write_wrn_cycles[%0d]: got %0d want 2", i, wrn_low); end
      n_vec++; if (bus_bad != 0) begin n_err++; $display("FAIL write_bus_count[%0d]: got %0d bad want 0", i, bus_bad); end
      n_vec++; if (rdn_low != 0) begin n_err++; $display("FAIL write_rdn[%0d]: got %0d low cycles want 0", i, rdn_low); end
      @(negedge Clk);
      n_vec++; if (wrn !== 1'b1 || Stall !== 1'b0) begin n_err++; $display("FAIL write_after[%0d]: got wrn %b stall %b want 1 0", i, wrn, Stall); end
    end
  endtask

  task automatic test_rst_mid_write();
    step();
    Addr = 16'hBF00; MemWrite = 1'b1; WrData = 16'($urandom); tbre = 1'b1; tsre = 1'b1;
    step();
    step();
    @(negedge Clk);
    n_vec++; if (wrn !== 1'b0) begin n_err++; $display("FAIL rstw_strobe: got wrn %b want 0", wrn); end
    step();
    Rst = 1'b1; bus_idle();
    step();
    Rst = 1'b0;
    @(negedge Clk);
    n_vec++; if (wrn !== 1'b1) begin n_err++; $display("FAIL rstw_wrn: got %b want 1", wrn); end
    n_vec++; if (Stall !== 1'b0) begin n_err++; $display("FAIL rstw_stall: got %b want 0", Stall); end
    n_vec++; if (rdn !== 1'b1) begin n_err++; $display("FAIL rstw_rdn: got %b want 1", rdn); end
    step();
    Addr = 16'hBF01; MemRead = 1'b1;
    @(negedge Clk);
    n_vec++; if (RdData !== 16'h0001) begin n_err++; $display("FAIL rstw_idle_status: got %h want 0001", RdData); end
    step();
    bus_idle();
    @(negedge Clk);
    n_vec++; if (wrn !== 1'b1) begin n_err++; $display("FAIL rstw_quiet: got wrn %b want 1", wrn); end
  endtask

  task automatic test_outside();
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      logic rd, wr;
      if (i == 0)      begin a = 16'h8000; rd = 1'b1; wr = 1'b0; end
      else if (i == 1) begin a = 16'h1234; rd = 1'b0; wr = 1'b1; end
      else begin
        a = 16'($urandom);
        if (a[15:1] == 15'h5F80) a = a ^ 16'h0100;
        wr = 1'($urandom);
        rd = wr ? 1'($urandom) : 1'b1;
      end
      step();
      Addr = a; MemRead = rd; MemWrite = wr; WrData = 16'($urandom);
      tbre = 1'($urandom); tsre = 1'($urandom);
      for (int c = 0; c < 2; c++) begin
        @(negedge Clk);
        n_vec++;
        if (UartSel !== 1'b0 || Stall !== 1'b0 || rdn !== 1'b1 || wrn !== 1'b1 || RdData !== 16'h0000) begin
          n_err++;
          $display("FAIL outside[%h]: got sel %b stall %b rdn %b wrn %b rd %h want 0 0 1 1 0000", a, UartSel, Stall, rdn, wrn, RdData);
        end
        if (c == 0) step();
      end
      step();
      bus_idle();
    end
    tbre = 1'b1; tsre = 1'b1;
  endtask

  task automatic test_fifo();
    int pulses, stall_n;
    logic prev;
    logic [7:0] sent[$];
    step();
    tbre = 1'b1; tsre = 1'b1;
    for (int b = 1; b <= 5; b++) begin rxq.push_back(8'(b)); sent.push_back(8'(b)); end
    pulses = 0; stall_n = 0; prev = 1'b1;
    repeat (40) begin
      @(negedge Clk);
      if (prev && !rdn) pulses++;
      prev = rdn;
      if (Stall) stall_n++;
    end
    n_vec++; if (pulses != 4) begin n_err++; $display("FAIL fifo_fill_pulses: got %0d want 4", pulses); end
    n_vec++; if (rxq.size() != 1) begin n_err++; $display("FAIL fifo_fill_left: got %0d want 1", rxq.size()); end
    n_vec++; if (stall_n != 0) begin n_err++; $display("FAIL fifo_fill_stall: got %0d want 0", stall_n); end
    step();
    Addr = 16'hBF01; MemRead = 1'b1;
    @(negedge Clk);
    n_vec++; if (RdData !== 16'h0003) begin n_err++; $display("FAIL fifo_status: got %h want 0003", RdData); end
    for (int k = 0; k < 4; k++) begin
      step();
      Addr = 16'hBF00; MemRead = 1'b1;
      @(negedge Clk);
      n_vec++; if (RdData !== {8'h00, sent[k]}) begin n_err++; $display("FAIL fifo_pop[%0d]: got %h want %h", k, RdData, {8'h00, sent[k]}); end
      n_vec++; if (Stall !== 1'b0 || rdn !== 1'b1) begin n_err++; $display("FAIL fifo_pop_ctl[%0d]: got stall %b rdn %b want 0 1", k, Stall, rdn); end
    end
    step();
    bus_idle();
    pulses = 0; prev = 1'b1;
    repeat (20) begin
      @(negedge Clk);
      if (prev && !rdn) pulses++;
      prev = rdn;
    end
    n_vec++; if (pulses != 1 || rxq.size() != 0) begin n_err++; $display("FAIL fifo_fifth: got %0d pulses %0d left want 1 0", pulses, rxq.size()); end
    step();
    Addr = 16'hBF00; MemRead = 1'b1;
    @(negedge Clk);
    n_vec++; if (RdData !== {8'h00, sent[4]} || Stall !== 1'b0) begin n_err++; $display("FAIL fifo_last: got %h stall %b want %h 0", RdData, Stall, {8'h00, sent[4]}); end
    step();
    bus_idle();
  endtask

  initial begin
    Rst = 1'b1; tbre = 1'b1; tsre = 1'b1;
    bus_idle();
    test_reset();
    test_status();
`ifdef UART_RX_FIFO_EN
    test_fifo();
`else
    test_read();
    test_read_empty();
`endif
    test_write();
    test_rst_mid_write();
    test_outside();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
